// File: rtl/me_frame_scheduler.sv
// me_frame_scheduler: walks a BLK_COLS x BLK_ROWS frame of template blocks and
// runs one 4-phase req/ack handshake with me_top per block. It presents the
// block coordinates and base address, then emits each block's min SAD and
// motion vector on a valid/ready result stream.
//
// Result stream handshake: a result transfers on a rising clk edge where
// res_valid=1 and res_ready=1. Once res_valid is high, res_sad/res_mvec/res_idx
// stay frozen and res_valid stays high until that transfer happens.
//
// Optional build macro ME_SCHED_STATS_EN adds sad_total/sad_max outputs.
// dbg_state exposes the FSM encoding (0 IDLE, 1 REQ, 2 CAPT, 3 REL, 4 OUT, 5 FIN).
module me_frame_scheduler #(
  parameter int TB_LENGTH    = 16,
  parameter int SW_LENGTH    = 64,
  parameter int PE_OUT_WIDTH = 8,
  parameter int BLK_COLS     = 4,
  parameter int BLK_ROWS     = 4,
  localparam int CNT_WIDTH   = $clog2((SW_LENGTH - TB_LENGTH + 1) ** 2),
  localparam int SAD_WIDTH   = $clog2(TB_LENGTH ** 2) + PE_OUT_WIDTH,
  localparam int NBLK        = BLK_COLS * BLK_ROWS,
  localparam int IDX_WIDTH   = ($clog2(NBLK) > 1) ? $clog2(NBLK) : 1,
  localparam int ADDR_WIDTH  = $clog2(NBLK * TB_LENGTH ** 2),
  localparam int X_WIDTH     = $clog2(BLK_COLS) + 1,
  localparam int Y_WIDTH     = $clog2(BLK_ROWS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  me_req,
  input  logic                  me_ack,
  input  logic [SAD_WIDTH-1:0]  me_min_sad,
  input  logic [CNT_WIDTH-1:0]  me_min_mvec,
  output logic [X_WIDTH-1:0]    blk_x,
  output logic [Y_WIDTH-1:0]    blk_y,
  output logic [ADDR_WIDTH-1:0] tb_base,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [SAD_WIDTH-1:0]  res_sad,
  output logic [CNT_WIDTH-1:0]  res_mvec,
  output logic [IDX_WIDTH-1:0]  res_idx,
`ifdef ME_SCHED_STATS_EN
  output logic [SAD_WIDTH+IDX_WIDTH:0] sad_total,
  output logic [SAD_WIDTH-1:0]         sad_max,
`endif
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_CAPT = 3'd2,
    S_REL  = 3'd3,
    S_OUT  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [X_WIDTH-1:0]    blk_x_q, blk_x_d;
  logic [Y_WIDTH-1:0]    blk_y_q, blk_y_d;
  logic [ADDR_WIDTH-1:0] tb_base_q, tb_base_d;
  logic [SAD_WIDTH-1:0]  res_sad_q, res_sad_d;
  logic [CNT_WIDTH-1:0]  res_mvec_q, res_mvec_d;
  logic [IDX_WIDTH-1:0]  res_idx_q, res_idx_d;
  logic                  abort_flag_q, abort_flag_d;
  logic                  me_req_q, me_req_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  res_valid_q, res_valid_d;
  logic                  last_blk;
  logic                  accept;
  logic [IDX_WIDTH-1:0]  cur_idx;
`ifdef ME_SCHED_STATS_EN
  logic [SAD_WIDTH+IDX_WIDTH:0] sad_total_q, sad_total_d;
  logic [SAD_WIDTH-1:0]         sad_max_q, sad_max_d;
`endif

  // Next-state, block stepping, result capture and registered-output decode.
  always_comb begin
    state_d      = state_q;
    blk_x_d      = blk_x_q;
    blk_y_d      = blk_y_q;
    res_sad_d    = res_sad_q;
    res_mvec_d   = res_mvec_q;
    res_idx_d    = res_idx_q;
    // Abort is sticky once a frame is running; it only takes effect at the
    // next result accept so the in-flight handshake always completes.
    abort_flag_d = abort_flag_q | (abort & (state_q != S_IDLE));
    last_blk     = (blk_x_q == X_WIDTH'(BLK_COLS - 1)) &&
                   (blk_y_q == Y_WIDTH'(BLK_ROWS - 1));
    cur_idx      = IDX_WIDTH'(int'(blk_y_q) * BLK_COLS + int'(blk_x_q));
    accept       = (state_q == S_OUT) && res_ready;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          blk_x_d      = '0;
          blk_y_d      = '0;
          abort_flag_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        if (me_ack) begin
          res_sad_d  = me_min_sad;
          res_mvec_d = me_min_mvec;
          res_idx_d  = cur_idx;
          state_d    = S_CAPT;
        end
      end
      S_CAPT: state_d = S_REL;
      // 4-phase: ack must fall before the next request may be raised.
      S_REL: begin
        if (!me_ack) state_d = S_OUT;
      end
      S_OUT: begin
        if (res_ready) begin
          if (last_blk || abort_flag_d) begin
            state_d = S_FIN;
          end else begin
            if (blk_x_q == X_WIDTH'(BLK_COLS - 1)) begin
              blk_x_d = '0;
              blk_y_d = blk_y_q + 1'b1;
            end else begin
              blk_x_d = blk_x_q + 1'b1;
            end
            state_d = S_REQ;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Base address tracks the next block so it is valid on the first me_req cycle.
    tb_base_d   = ADDR_WIDTH'((int'(blk_y_d) * BLK_COLS + int'(blk_x_d)) * TB_LENGTH * TB_LENGTH);
    me_req_d    = (state_d == S_REQ);
    busy_d      = (state_d == S_REQ) || (state_d == S_CAPT) ||
                  (state_d == S_REL) || (state_d == S_OUT);
    res_valid_d = (state_d == S_OUT);
    done_d      = (state_d == S_FIN);
    aborted_d   = (state_d == S_FIN) && abort_flag_d;

`ifdef ME_SCHED_STATS_EN
    sad_total_d = sad_total_q;
    sad_max_d   = sad_max_q;
    if ((state_q == S_IDLE) && start) begin
      sad_total_d = '0;
      sad_max_d   = '0;
    end else if (accept) begin
      sad_total_d = sad_total_q + (SAD_WIDTH + IDX_WIDTH + 1)'(res_sad_q);
      if (res_sad_q > sad_max_q) sad_max_d = res_sad_q;
    end
`endif
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      blk_x_q      <= '0;
      blk_y_q      <= '0;
      tb_base_q    <= '0;
      res_sad_q    <= '0;
      res_mvec_q   <= '0;
      res_idx_q    <= '0;
      abort_flag_q <= 1'b0;
      me_req_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      res_valid_q  <= 1'b0;
`ifdef ME_SCHED_STATS_EN
      sad_total_q  <= '0;
      sad_max_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      blk_x_q      <= blk_x_d;
      blk_y_q      <= blk_y_d;
      tb_base_q    <= tb_base_d;
      res_sad_q    <= res_sad_d;
      res_mvec_q   <= res_mvec_d;
      res_idx_q    <= res_idx_d;
      abort_flag_q <= abort_flag_d;
      me_req_q     <= me_req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      res_valid_q  <= res_valid_d;
`ifdef ME_SCHED_STATS_EN
      sad_total_q  <= sad_total_d;
      sad_max_q    <= sad_max_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign me_req    = me_req_q;
  assign blk_x     = blk_x_q;
  assign blk_y     = blk_y_q;
  assign tb_base   = tb_base_q;
  assign res_valid = res_valid_q;
  assign res_sad   = res_sad_q;
  assign res_mvec  = res_mvec_q;
  assign res_idx   = res_idx_q;
  assign dbg_state = state_q;
`ifdef ME_SCHED_STATS_EN
  assign sad_total = sad_total_q;
  assign sad_max   = sad_max_q;
`endif

endmodule

// File: tb/tb_me_frame_scheduler.sv
// Directed bench for me_frame_scheduler on a 2x2 frame with a behavioural
// me_top responder (programmable ack latency and ack release delay).
module tb_me_frame_scheduler;

  localparam int TB_LENGTH = 16;
  localparam int SW_LENGTH = 64;
  localparam int PE_OUT_W  = 8;
  localparam int COLS      = 2;
  localparam int ROWS      = 2;
  localparam int CNT_W     = $clog2((SW_LENGTH - TB_LENGTH + 1) ** 2);
  localparam int SAD_W     = $clog2(TB_LENGTH ** 2) + PE_OUT_W;
  localparam int NBLK      = COLS * ROWS;
  localparam int IDX_W     = ($clog2(NBLK) > 1) ? $clog2(NBLK) : 1;
  localparam int ADDR_W    = $clog2(NBLK * TB_LENGTH ** 2);
  localparam int X_W       = $clog2(COLS) + 1;
  localparam int Y_W       = $clog2(ROWS) + 1;
  localparam int W         = IDX_W + SAD_W + CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, abort, res_ready;
  logic              busy, done, aborted, me_req, res_valid;
  logic              me_ack;
  logic [SAD_W-1:0]  me_min_sad, res_sad;
  logic [CNT_W-1:0]  me_min_mvec, res_mvec;
  logic [X_W-1:0]    blk_x;
  logic [Y_W-1:0]    blk_y;
  logic [ADDR_W-1:0] tb_base;
  logic [IDX_W-1:0]  res_idx;
  logic [2:0]        dbg_state;
`ifdef ME_SCHED_STATS_EN
  logic [SAD_W+IDX_W:0] sad_total;
  logic [SAD_W-1:0]     sad_max;
`endif

  me_frame_scheduler #(
    .TB_LENGTH(TB_LENGTH), .SW_LENGTH(SW_LENGTH), .PE_OUT_WIDTH(PE_OUT_W),
    .BLK_COLS(COLS), .BLK_ROWS(ROWS)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted),
    .me_req(me_req), .me_ack(me_ack), .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec),
    .blk_x(blk_x), .blk_y(blk_y), .tb_base(tb_base),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sad(res_sad), .res_mvec(res_mvec), .res_idx(res_idx),
`ifdef ME_SCHED_STATS_EN
    .sad_total(sad_total), .sad_max(sad_max),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0]     exp_q[$];
  logic [SAD_W-1:0] sad_tbl [4];
  logic [CNT_W-1:0] mvec_tbl[4];
  int ack_lat  = 20;
  int ack_hold = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- me_top responder ----------------
  // Answers each request with the table entry for the block at tb_base,
  // holds ack until req drops, then keeps it ack_hold more cycles.
  initial begin
    int mi;
    me_ack      = 1'b0;
    me_min_sad  = '0;
    me_min_mvec = '0;
    forever begin
      @(negedge clk);
      if (me_req === 1'b1) begin
        for (int i = 0; i < ack_lat && me_req === 1'b1; i++) @(negedge clk);
        if (me_req === 1'b1) begin
          mi          = int'(tb_base >> 8) & 3;
          me_min_sad  = sad_tbl[mi];
          me_min_mvec = mvec_tbl[mi];
          me_ack      = 1'b1;
          while (me_req === 1'b1) @(negedge clk);
          repeat (ack_hold) @(negedge clk);
          me_ack      = 1'b0;
          me_min_sad  = '0;
          me_min_mvec = '0;
        end
      end
    end
  end

  // ---------------- event monitor ----------------
  int   done_cnt    = 0;
  int   req_cnt     = 0;
  int   reissue_cnt = 0;
  logic req_prev    = 1'b0;
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_cnt++;
    if (me_req === 1'b1 && req_prev !== 1'b1) begin
      req_cnt++;
      if (me_ack === 1'b1) reissue_cnt++;
    end
    req_prev = me_req;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (me_req === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (res_valid === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output bit got, output logic ab);
    got = 1'b0;
    ab  = 1'bx;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin got = 1'b1; ab = aborted; break; end
      @(negedge clk);
    end
  endtask

  // One frame: n_exp results expected; bp_blk gets 10 cycles of backpressure,
  // abort_blk has abort pulsed during its REQ, slow checks the ack release wait.
  task automatic run_frame(input int n_exp, input int bp_blk, input int abort_blk,
                           input bit exp_ab, input bit slow);
    logic [W-1:0] e;
    bit           got, stable;
    logic         ab;
    int           d0, r0;
    logic [31:0]  exp_total, exp_max;
    d0 = done_cnt;
    r0 = req_cnt;
    exp_total = 0;
    exp_max   = 0;
    for (int b = 0; b < n_exp; b++) begin
      exp_q.push_back({IDX_W'(b), sad_tbl[b], mvec_tbl[b]});
      exp_total += 32'(sad_tbl[b]);
      if (32'(sad_tbl[b]) > exp_max) exp_max = 32'(sad_tbl[b]);
    end
    pulse_start();
    for (int b = 0; b < n_exp; b++) begin
      wait_req(got);
      check("req_seen", 32'(got), 32'd1);
      check("tb_base", 32'(tb_base), 32'(b * TB_LENGTH * TB_LENGTH));
      check("blk_x", 32'(blk_x), 32'(b % COLS));
      check("blk_y", 32'(blk_y), 32'(b / COLS));
`ifdef ME_SCHED_STATS_EN
      if (b == 0) begin
        check("stats_clr_total", 32'(sad_total), 32'd0);
        check("stats_clr_max", 32'(sad_max), 32'd0);
      end
`endif
      if (b == abort_blk) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
      if (b == bp_blk) res_ready = 1'b0;
      if (slow && b == 0) begin
        for (int i = 0; i < 40 && me_ack !== 1'b1; i++) @(negedge clk);
        for (int i = 0; i < 5 && me_req !== 1'b0; i++) @(negedge clk);
        stable = 1'b1;
        repeat (3) begin
          @(negedge clk);
          stable &= (me_req === 1'b0) && (dbg_state === 3'd3);
        end
        check("slow_rel_hold", 32'(stable), 32'd1);
      end
      wait_valid(got);
      check("valid_seen", 32'(got), 32'd1);
      e = exp_q.pop_front();
      check("res_idx", 32'(res_idx), 32'(e[W-1 -: IDX_W]));
      check("res_sad", 32'(res_sad), 32'(e[CNT_W +: SAD_W]));
      check("res_mvec", 32'(res_mvec), 32'(e[CNT_W-1:0]));
      if (b == bp_blk) begin
        stable = 1'b1;
        repeat (10) begin
          @(negedge clk);
          stable &= (res_valid === 1'b1) && (me_req === 1'b0) &&
                    (res_sad === e[CNT_W +: SAD_W]) && (res_idx === e[W-1 -: IDX_W]) &&
                    (res_mvec === e[CNT_W-1:0]);
        end
        check("bp_stable", 32'(stable), 32'd1);
        res_ready = 1'b1;
      end
      @(negedge clk);
    end
    wait_done(got, ab);
    check("done_seen", 32'(got), 32'd1);
    check("aborted", 32'(ab), 32'(exp_ab));
`ifdef ME_SCHED_STATS_EN
    check("sad_total", 32'(sad_total), exp_total);
    check("sad_max", 32'(sad_max), exp_max);
`endif
    repeat (5) @(negedge clk);
    check("single_done", 32'(done_cnt - d0), 32'd1);
    check("req_count", 32'(req_cnt - r0), 32'(n_exp));
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_state", 32'(dbg_state), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0;
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    res_ready = 1'b1;
    sad_tbl   = '{16'd10, 16'd40, 16'd25, 16'd5};
    mvec_tbl  = '{12'd7, 12'd300, 12'd12, 12'd4095};
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_me_req", 32'(me_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_tb_base", 32'(tb_base), 32'd0);
    check("rst_res_idx", 32'(res_idx), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
`ifdef ME_SCHED_STATS_EN
    check("rst_sad_total", 32'(sad_total), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Reset arriving while a request is outstanding.
    pulse_start();
    repeat (2) @(negedge clk);
    check("midreq_req", 32'(me_req), 32'd1);
    check("midreq_state", 32'(dbg_state), 32'd1);
    d0  = done_cnt;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_req", 32'(me_req), 32'd0);
    check("midrst_valid", 32'(res_valid), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_stay_idle", 32'(me_req), 32'd0);

    // Full frame, fast consumer.
    run_frame(4, -1, -1, 1'b0, 1'b0);

    // Slow ack release on every block, backpressure on block 1.
    ack_hold = 5;
    run_frame(4, 1, -1, 1'b0, 1'b1);
    ack_hold = 0;

    // Abort while block 1 is requesting: block 1 still reported, then stop.
    run_frame(2, -1, 1, 1'b1, 1'b0);

    // Abort while idle has no effect; next frame runs to completion.
    ack_lat = 2;
    abort   = 1'b1;
    repeat (3) @(negedge clk);
    abort   = 1'b0;
    check("idle_abort_state", 32'(dbg_state), 32'd0);
    run_frame(4, -1, -1, 1'b0, 1'b0);

    check("no_reissue_under_ack", 32'(reissue_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
